// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the memory stage: icodes, status codes and FSM states.
package y86_pkg;

    localparam logic [3:0] HALT   = 4'h0;
    localparam logic [3:0] NOP    = 4'h1;
    localparam logic [3:0] RRMOVQ = 4'h2;
    localparam logic [3:0] IRMOVQ = 4'h3;
    localparam logic [3:0] RMMOVQ = 4'h4;
    localparam logic [3:0] MRMOVQ = 4'h5;
    localparam logic [3:0] OPQ    = 4'h6;
    localparam logic [3:0] JXX    = 4'h7;
    localparam logic [3:0] CALL   = 4'h8;
    localparam logic [3:0] RET    = 4'h9;
    localparam logic [3:0] PUSHQ  = 4'hA;
    localparam logic [3:0] POPQ   = 4'hB;

    localparam logic [3:0] RNONE  = 4'hF;

    localparam logic [2:0] AOK = 3'd1;
    localparam logic [2:0] HLT = 3'd2;
    localparam logic [2:0] ADR = 3'd3;
    localparam logic [2:0] INS = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_e;

    function automatic logic is_mem_write(input logic [3:0] icode);
        return (icode == RMMOVQ) || (icode == CALL) || (icode == PUSHQ);
    endfunction

    function automatic logic is_mem_read(input logic [3:0] icode);
        return (icode == MRMOVQ) || (icode == RET) || (icode == POPQ);
    endfunction

endpackage

// File: rtl/y86_dmem.sv
// Single-port synchronous data RAM; read data is registered, contents are never reset.
module y86_dmem #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 1024,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/y86_mem_stage.sv
// Y86-64 memory stage: multi-cycle data access with address checking, status merge and sticky halt.
module y86_mem_stage
    import y86_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              M_valid,
    input  logic [3:0]        M_icode,
    input  logic [3:0]        M_ifun,
    input  logic [DATA_W-1:0] M_valA,
    input  logic [DATA_W-1:0] M_valE,
    input  logic [3:0]        M_dstE,
    input  logic [3:0]        M_dstM,
    input  logic [2:0]        M_stat,
    output logic              m_stall,
    output logic              W_valid,
    output logic [3:0]        W_icode,
    output logic [3:0]        W_ifun,
    output logic [3:0]        W_dstE,
    output logic [3:0]        W_dstM,
    output logic [DATA_W-1:0] W_valE,
    output logic [DATA_W-1:0] W_valM,
    output logic [2:0]        W_stat,
    output logic              halted,
    output mem_state_e        dbg_state
);

    localparam int IDX_W = $clog2(DEPTH);

    mem_state_e        state;
    logic [2:0]        cnt;
    logic [3:0]        l_icode, l_ifun, l_dstE, l_dstM;
    logic [DATA_W-1:0] l_valA, l_valE;
    logic [2:0]        l_stat;

    logic              accept, use_wait, enter_done;
    logic [3:0]        c_icode;
    logic [DATA_W-1:0] c_valA, c_valE, c_addr;
    logic [2:0]        c_stat, fin_stat;
    logic              c_wr, c_rd, c_mem, c_ok;
    logic              mem_we, mem_re;
    logic [DATA_W-1:0] rdata;

    // Handshake: an instruction moves in on a rising edge with M_valid=1 while
    // m_stall=0 and not halted; upstream holds M_* stable whenever m_stall=1.
    assign m_stall   = (state != IDLE);
    assign accept    = M_valid && (state == IDLE) && !halted;
    assign dbg_state = state;

    // In IDLE the access is decoded from the live inputs, otherwise from the latched copy.
    assign c_icode = (state == IDLE) ? M_icode : l_icode;
    assign c_valA  = (state == IDLE) ? M_valA  : l_valA;
    assign c_valE  = (state == IDLE) ? M_valE  : l_valE;
    assign c_stat  = (state == IDLE) ? M_stat  : l_stat;

    assign c_wr   = is_mem_write(c_icode);
    assign c_rd   = is_mem_read(c_icode);
    assign c_mem  = c_wr || c_rd;
    assign c_addr = ((c_icode == RET) || (c_icode == POPQ)) ? c_valA : c_valE;
    assign c_ok   = (c_addr[2:0] == 3'd0) && ((c_addr >> 3) < DATA_W'(DEPTH));

    assign use_wait   = c_mem && (LATENCY > 0);
    assign enter_done = (accept && !use_wait) || ((state == WAIT) && (cnt == 3'd0));

    // The access happens on the edge that enters DONE, so DONE sees the read data.
    assign mem_we = enter_done && c_wr && c_ok && (c_stat == AOK);
    assign mem_re = enter_done && c_rd;

    assign fin_stat = (c_stat != AOK)      ? c_stat :
                      (c_mem && !c_ok)     ? ADR    :
                      (c_icode == HALT)    ? HLT    : AOK;

    y86_dmem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_dmem (
        .clk   (clk),
        .we    (mem_we),
        .re    (mem_re),
        .idx   (c_addr[IDX_W+2:3]),
        .wdata (c_valA),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 3'd0;
            halted  <= 1'b0;
            l_icode <= 4'd0;
            l_ifun  <= 4'd0;
            l_dstE  <= 4'd0;
            l_dstM  <= 4'd0;
            l_valA  <= '0;
            l_valE  <= '0;
            l_stat  <= AOK;
            W_valid <= 1'b0;
            W_icode <= 4'd0;
            W_ifun  <= 4'd0;
            W_dstE  <= 4'd0;
            W_dstM  <= 4'd0;
            W_valE  <= '0;
            W_valM  <= '0;
            W_stat  <= AOK;
        end else begin
            W_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        l_icode <= M_icode;
                        l_ifun  <= M_ifun;
                        l_dstE  <= M_dstE;
                        l_dstM  <= M_dstM;
                        l_valA  <= M_valA;
                        l_valE  <= M_valE;
                        l_stat  <= M_stat;
                        if (use_wait) begin
                            state <= WAIT;
                            cnt   <= 3'(LATENCY - 1);
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 3'd0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                DONE: begin
                    W_valid <= 1'b1;
                    W_icode <= l_icode;
                    W_ifun  <= l_ifun;
                    W_dstE  <= l_dstE;
                    W_dstM  <= l_dstM;
                    W_valE  <= l_valE;
                    W_valM  <= (c_rd && (fin_stat == AOK)) ? rdata : '0;
                    W_stat  <= fin_stat;
                    if (fin_stat != AOK) begin
                        halted <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_y86_mem_stage.sv
// Self-checking bench for y86_mem_stage: LATENCY=2 instance against a word-level model, LATENCY=0 instance for timing.
module tb_y86_mem_stage;
    import y86_pkg::*;

    localparam int DW    = 64;
    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    // ---------------- clock / reset / DUT signals ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          M_valid = 1'b0;
    logic          m0_valid = 1'b0;
    logic [3:0]    M_icode = 4'd0, M_ifun = 4'd0, M_dstE = RNONE, M_dstM = RNONE;
    logic [DW-1:0] M_valA = '0, M_valE = '0;
    logic [2:0]    M_stat = AOK;

    logic          m_stall, W_valid, halted;
    logic [3:0]    W_icode, W_ifun, W_dstE, W_dstM;
    logic [DW-1:0] W_valE, W_valM;
    logic [2:0]    W_stat;
    mem_state_e    dbg_state;

    logic          m0_stall, W0_valid, halted0;
    logic [3:0]    W0_icode, W0_ifun, W0_dstE, W0_dstM;
    logic [DW-1:0] W0_valE, W0_valM;
    logic [2:0]    W0_stat;
    mem_state_e    dbg_state0;

    y86_mem_stage #(.DATA_W(DW), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .M_valid(M_valid), .M_icode(M_icode), .M_ifun(M_ifun),
        .M_valA(M_valA), .M_valE(M_valE), .M_dstE(M_dstE), .M_dstM(M_dstM), .M_stat(M_stat),
        .m_stall(m_stall), .W_valid(W_valid), .W_icode(W_icode), .W_ifun(W_ifun),
        .W_dstE(W_dstE), .W_dstM(W_dstM), .W_valE(W_valE), .W_valM(W_valM), .W_stat(W_stat),
        .halted(halted), .dbg_state(dbg_state)
    );

    y86_mem_stage #(.DATA_W(DW), .DEPTH(DEPTH), .LATENCY(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .M_valid(m0_valid), .M_icode(M_icode), .M_ifun(M_ifun),
        .M_valA(M_valA), .M_valE(M_valE), .M_dstE(M_dstE), .M_dstM(M_dstM), .M_stat(M_stat),
        .m_stall(m0_stall), .W_valid(W0_valid), .W_icode(W0_icode), .W_ifun(W0_ifun),
        .W_dstE(W0_dstE), .W_dstM(W0_dstM), .W_valE(W0_valE), .W_valM(W0_valM), .W_stat(W0_stat),
        .halted(halted0), .dbg_state(dbg_state0)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem_model [longint];
    bit            model_halted = 0;
    logic [DW-1:0] exp_q [$];

    logic [3:0]    cur_ifun, cur_dstE, cur_dstM;
    bit            obs_got;
    int            obs_stalls, obs_lat;
    logic [3:0]    obs_icode, obs_ifun, obs_dstE, obs_dstM;
    logic [DW-1:0] obs_valE, obs_valM;
    logic [2:0]    obs_stat;
    logic          obs_halted;

    // Word-addressed memory model: legality, status priority and write effect.
    task automatic model_op(input logic [3:0] icode, input logic [DW-1:0] valA, input logic [DW-1:0] valE,
                            input logic [2:0] stat, output logic [2:0] e_stat, output logic [DW-1:0] e_valM);
        bit wr, rd, legal;
        logic [DW-1:0] addr;
        wr    = icode inside {RMMOVQ, CALL, PUSHQ};
        rd    = icode inside {MRMOVQ, RET, POPQ};
        addr  = (icode inside {RET, POPQ}) ? valA : valE;
        legal = (addr % 8 == 0) && (addr < 8 * DEPTH);
        if (stat != AOK)               e_stat = stat;
        else if ((wr || rd) && !legal) e_stat = ADR;
        else if (icode == HALT)        e_stat = HLT;
        else                           e_stat = AOK;
        e_valM = (rd && e_stat == AOK) ? mem_model[longint'(addr / 8)] : '0;
        if (wr && e_stat == AOK) mem_model[longint'(addr / 8)] = valA;
        if (e_stat != AOK) model_halted = 1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic reset_dut();
        @(negedge clk);
        M_valid = 1'b0;
        m0_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_halted = 0;
        @(negedge clk);
    endtask

    // Offer one instruction to dut (sel=0) or dut0 (sel=1) and capture its writeback, if any.
    task automatic do_op(input bit sel, input logic [3:0] icode, input logic [DW-1:0] valA,
                         input logic [DW-1:0] valE, input logic [2:0] stat);
        int n;
        n = 0;
        while ((sel ? m0_stall : m_stall) && n < 20) begin
            @(negedge clk);
            n++;
        end
        cur_ifun = 4'($urandom_range(0, 15));
        cur_dstE = 4'($urandom_range(0, 15));
        cur_dstM = 4'($urandom_range(0, 15));
        M_icode = icode; M_ifun = cur_ifun; M_valA = valA; M_valE = valE;
        M_stat = stat; M_dstE = cur_dstE; M_dstM = cur_dstM;
        if (sel) m0_valid = 1'b1; else M_valid = 1'b1;
        @(posedge clk);
        #1;
        M_valid = 1'b0;
        m0_valid = 1'b0;
        obs_got = 0;
        obs_stalls = 0;
        obs_lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (sel ? W0_valid : W_valid) begin
                obs_got = 1;
                obs_lat = i;
                obs_icode = sel ? W0_icode : W_icode;
                obs_ifun  = sel ? W0_ifun  : W_ifun;
                obs_dstE  = sel ? W0_dstE  : W_dstE;
                obs_dstM  = sel ? W0_dstM  : W_dstM;
                obs_valE  = sel ? W0_valE  : W_valE;
                obs_valM  = sel ? W0_valM  : W_valM;
                obs_stat  = sel ? W0_stat  : W_stat;
                obs_halted = sel ? halted0 : halted;
                break;
            end
            if (sel ? m0_stall : m_stall) obs_stalls++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({W_valid, m_stall, halted} !== 3'b000 || W_stat !== AOK || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL reset_ctrl: valid/stall/halted=%b stat=%0d state=%0d, required 000 stat=1 state=0",
                     {W_valid, m_stall, halted}, W_stat, dbg_state);
        end
        checks++;
        if ({W_icode, W_ifun, W_dstE, W_dstM, W_valE, W_valM} !== '0) begin
            errors++;
            $display("FAIL reset_data: icode=%h ifun=%h dstE=%h dstM=%h valE=%h valM=%h, required all 0",
                     W_icode, W_ifun, W_dstE, W_dstM, W_valE, W_valM);
        end
        checks++;
        if ({W0_valid, m0_stall, halted0} !== 3'b000 || W0_stat !== AOK || W0_valE !== '0) begin
            errors++;
            $display("FAIL reset_lat0: valid/stall/halted=%b stat=%0d valE=%h, required 000 stat=1 valE=0",
                     {W0_valid, m0_stall, halted0}, W0_stat, W0_valE);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_store_load();
        logic [2:0] es;
        logic [DW-1:0] ev;
        do_op(0, RMMOVQ, 64'h123, 64'h40, AOK);
        model_op(RMMOVQ, 64'h123, 64'h40, AOK, es, ev);
        checks++;
        if (!obs_got || obs_stalls != 3 || obs_stat !== AOK || obs_valE !== 64'h40 || obs_icode !== RMMOVQ) begin
            errors++;
            $display("FAIL store: got=%0b stalls=%0d stat=%0d valE=%h icode=%h, required 1 3 1 40 4",
                     obs_got, obs_stalls, obs_stat, obs_valE, obs_icode);
        end
        do_op(0, MRMOVQ, 64'h0, 64'h40, AOK);
        model_op(MRMOVQ, 64'h0, 64'h40, AOK, es, ev);
        checks++;
        if (!obs_got || obs_stalls != 3 || obs_stat !== AOK || obs_valM !== 64'h123) begin
            errors++;
            $display("FAIL load: got=%0b stalls=%0d stat=%0d valM=%h, required 1 3 1 123",
                     obs_got, obs_stalls, obs_stat, obs_valM);
        end
    endtask

    task automatic test_latency0();
        do_op(1, OPQ, 64'h99, 64'd7, AOK);
        checks++;
        if (!obs_got || obs_lat != 2 || obs_stalls != 1 || obs_valE !== 64'd7 || obs_stat !== AOK) begin
            errors++;
            $display("FAIL lat0_opq: got=%0b lat=%0d stalls=%0d valE=%h stat=%0d, required 1 2 1 7 1",
                     obs_got, obs_lat, obs_stalls, obs_valE, obs_stat);
        end
        do_op(1, RMMOVQ, 64'hABC, 64'h10, AOK);
        do_op(1, MRMOVQ, 64'h0, 64'h10, AOK);
        checks++;
        if (!obs_got || obs_stalls != 1 || obs_valM !== 64'hABC) begin
            errors++;
            $display("FAIL lat0_load: got=%0b stalls=%0d valM=%h, required 1 1 abc", obs_got, obs_stalls, obs_valM);
        end
    endtask

    task automatic test_random();
        logic [3:0] ops [11] = '{NOP, RRMOVQ, IRMOVQ, OPQ, JXX, RMMOVQ, MRMOVQ, CALL, RET, PUSHQ, POPQ};
        logic [3:0] icode;
        logic [DW-1:0] a, e, addr, ev, want_m;
        logic [2:0] es;
        int want_st;
        for (int w = 0; w < 16; w++) begin
            a = {$urandom, $urandom};
            do_op(0, RMMOVQ, a, DW'(w * 8), AOK);
            model_op(RMMOVQ, a, DW'(w * 8), AOK, es, ev);
        end
        for (int i = 0; i < 40; i++) begin
            icode = ops[$urandom_range(0, 10)];
            addr = DW'($urandom_range(0, 15) * 8);
            a = {$urandom, $urandom};
            e = {$urandom, $urandom};
            if (icode inside {RMMOVQ, CALL, PUSHQ, MRMOVQ}) e = addr;
            if (icode inside {RET, POPQ}) a = addr;
            do_op(0, icode, a, e, AOK);
            model_op(icode, a, e, AOK, es, ev);
            exp_q.push_back(ev);
            want_m = exp_q.pop_front();
            want_st = (icode inside {RMMOVQ, CALL, PUSHQ, MRMOVQ, RET, POPQ}) ? LAT + 1 : 1;
            checks++;
            if (!obs_got || obs_stalls != want_st || obs_stat !== es || obs_valE !== e || obs_valM !== want_m ||
                {obs_icode, obs_ifun, obs_dstE, obs_dstM} !== {icode, cur_ifun, cur_dstE, cur_dstM}) begin
                errors++;
                $display("FAIL rand[%0d] icode=%h: got=%0b stalls=%0d stat=%0d valE=%h valM=%h fields=%h, required 1 %0d %0d %h %h %h",
                         i, icode, obs_got, obs_stalls, obs_stat, obs_valE, obs_valM,
                         {obs_icode, obs_ifun, obs_dstE, obs_dstM}, want_st, es, e, want_m,
                         {icode, cur_ifun, cur_dstE, cur_dstM});
            end
        end
    endtask

    task automatic test_stat_precedence();
        logic [2:0] es;
        logic [DW-1:0] ev;
        reset_dut();
        do_op(0, MRMOVQ, 64'h0, 64'h43, INS);
        model_op(MRMOVQ, 64'h0, 64'h43, INS, es, ev);
        checks++;
        if (!obs_got || obs_stat !== es || obs_stat !== INS || obs_valM !== '0 || obs_halted !== 1'b1) begin
            errors++;
            $display("FAIL stat_prec: got=%0b stat=%0d valM=%h halted=%b, required 1 4 0 1",
                     obs_got, obs_stat, obs_valM, obs_halted);
        end
    endtask

    task automatic test_misaligned();
        logic [2:0] es;
        logic [DW-1:0] ev;
        reset_dut();
        do_op(0, MRMOVQ, 64'h0, 64'h41, AOK);
        model_op(MRMOVQ, 64'h0, 64'h41, AOK, es, ev);
        checks++;
        if (!obs_got || obs_stat !== ADR || obs_valM !== '0 || obs_halted !== 1'b1) begin
            errors++;
            $display("FAIL misaligned: got=%0b stat=%0d valM=%h halted=%b, required 1 3 0 1",
                     obs_got, obs_stat, obs_valM, obs_halted);
        end
        do_op(0, RMMOVQ, 64'hDEAD, 64'h40, AOK);
        checks++;
        if (obs_got || obs_stalls != 0 || halted !== 1'b1) begin
            errors++;
            $display("FAIL halted_ignore: got=%0b stalls=%0d halted=%b, required 0 0 1", obs_got, obs_stalls, halted);
        end
        reset_dut();
        do_op(0, MRMOVQ, 64'h0, 64'h40, AOK);
        model_op(MRMOVQ, 64'h0, 64'h40, AOK, es, ev);
        checks++;
        if (!obs_got || obs_valM !== ev || obs_stat !== AOK) begin
            errors++;
            $display("FAIL halted_frozen: got=%0b valM=%h stat=%0d, required 1 %h 1", obs_got, obs_valM, obs_stat, ev);
        end
    endtask

    task automatic test_out_of_range();
        logic [2:0] es;
        logic [DW-1:0] ev;
        reset_dut();
        do_op(0, PUSHQ, 64'hBAD, 64'h2000, AOK);
        model_op(PUSHQ, 64'hBAD, 64'h2000, AOK, es, ev);
        checks++;
        if (!obs_got || obs_stat !== ADR || obs_halted !== 1'b1 || obs_valE !== 64'h2000) begin
            errors++;
            $display("FAIL oor_push: got=%0b stat=%0d halted=%b valE=%h, required 1 3 1 2000",
                     obs_got, obs_stat, obs_halted, obs_valE);
        end
        reset_dut();
        do_op(0, MRMOVQ, 64'h0, 64'h0, AOK);
        model_op(MRMOVQ, 64'h0, 64'h0, AOK, es, ev);
        checks++;
        if (!obs_got || obs_valM !== ev) begin
            errors++;
            $display("FAIL oor_nowrite: got=%0b word0=%h, required 1 %h", obs_got, obs_valM, ev);
        end
    endtask

    task automatic test_reset_wait();
        logic [2:0] es;
        logic [DW-1:0] ev, v1;
        reset_dut();
        v1 = {$urandom, $urandom};
        do_op(0, RMMOVQ, v1, 64'h80, AOK);
        model_op(RMMOVQ, v1, 64'h80, AOK, es, ev);
        M_icode = RMMOVQ; M_valA = 64'd5; M_valE = 64'h80; M_stat = AOK;
        M_valid = 1'b1;
        @(posedge clk);
        #1;
        M_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (dbg_state !== WAIT || m_stall !== 1'b1) begin
            errors++;
            $display("FAIL in_wait: state=%0d stall=%b, required 1 1", dbg_state, m_stall);
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if (dbg_state !== IDLE || {W_valid, m_stall, halted} !== 3'b000 || W_stat !== AOK ||
            W_valE !== '0 || W_icode !== 4'd0) begin
            errors++;
            $display("FAIL async_reset: state=%0d v/s/h=%b stat=%0d valE=%h icode=%h, required 0 000 1 0 0",
                     dbg_state, {W_valid, m_stall, halted}, W_stat, W_valE, W_icode);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(0, MRMOVQ, 64'h0, 64'h80, AOK);
        model_op(MRMOVQ, 64'h0, 64'h80, AOK, es, ev);
        checks++;
        if (!obs_got || obs_valM !== v1 || obs_valM !== ev) begin
            errors++;
            $display("FAIL reset_abandon: got=%0b valM=%h, required 1 %h", obs_got, obs_valM, v1);
        end
    endtask

    task automatic test_halt();
        logic [2:0] es;
        logic [DW-1:0] ev;
        reset_dut();
        do_op(0, HALT, 64'h0, 64'h0, AOK);
        model_op(HALT, 64'h0, 64'h0, AOK, es, ev);
        checks++;
        if (!obs_got || obs_stat !== HLT || obs_halted !== 1'b1 || obs_stalls != 1) begin
            errors++;
            $display("FAIL halt: got=%0b stat=%0d halted=%b stalls=%0d, required 1 2 1 1",
                     obs_got, obs_stat, obs_halted, obs_stalls);
        end
        M_icode = OPQ;
        M_valE = 64'd3;
        M_stat = AOK;
        M_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (m_stall !== 1'b0 || W_valid !== 1'b0 || halted !== 1'b1 || dbg_state !== IDLE) begin
                errors++;
                $display("FAIL halt_ignore[%0d]: stall=%b valid=%b halted=%b state=%0d, required 0 0 1 0",
                         i, m_stall, W_valid, halted, dbg_state);
            end
        end
        M_valid = 1'b0;
    endtask

    // ---------------- sequence + final report ----------------
    initial begin
        test_reset();
        test_store_load();
        test_latency0();
        test_random();
        test_stat_precedence();
        test_misaligned();
        test_out_of_range();
        test_reset_wait();
        test_halt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/y86_mem_stage.md
Y86_MEM_STAGE -- requirements
Module: y86_mem_stage

Interface
REQ-001 Parameter DATA_W, 64, memory word and value width in bits.
REQ-002 Parameter DEPTH, 1024, number of DATA_W-bit words in data memory.
REQ-003 Parameter LATENCY, 2, extra wait cycles per memory access; legal range 0..7.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 M_valid  input  1  execute/memory pipeline register holds a valid instruction.
REQ-007 M_icode, M_ifun  input  4 each  instruction code and function.
REQ-008 M_valA, M_valE  input  DATA_W each  store data / pop-ret address, and ALU result / address.
REQ-009 M_dstE, M_dstM  input  4 each  destination register IDs; 4'hF means none.
REQ-010 M_stat  input  3  incoming status: AOK=1, HLT=2, ADR=3, INS=4.
REQ-011 m_stall  output  1  stage busy; upstream holds M_* stable while high.
REQ-012 W_valid  output  1  writeback register holds a valid result.
REQ-013 W_icode, W_ifun, W_dstE, W_dstM  output  4 each  registered copies of the accepted inputs.
REQ-014 W_valE, W_valM  output  DATA_W each  passed ALU result and loaded memory data.
REQ-015 W_stat  output  3  final status after the memory-stage address check.
REQ-016 halted  output  1  sticky flag; set once a non-AOK status leaves the stage.

Function
REQ-017 Accept: an instruction is accepted on a rising edge where M_valid=1, m_stall=0 and halted=0.
REQ-018 Write ops: RMMOVQ, CALL, PUSHQ write M_valA to the word addressed by M_valE.
REQ-019 Read ops: MRMOVQ reads from M_valE; RET and POPQ read from M_valA.
REQ-020 Word index: word index = address[..:3]; an address is legal only if address[2:0]=0 and address < 8*DEPTH.
REQ-021 Illegal address: the write is suppressed, W_valM=0 and W_stat=ADR; an incoming non-AOK M_stat takes precedence and passes unchanged.
REQ-022 FSM states: IDLE, WAIT, DONE.
REQ-023 IDLE transitions: on accepting a memory op with LATENCY>0, go to WAIT and load wait counter with LATENCY-1; on a non-memory op or LATENCY=0, go to DONE.
REQ-024 WAIT: decrement the counter each cycle; at 0, perform the access and go to DONE.
REQ-025 DONE: lasts one cycle, loads the W_* registers with W_valid=1, then returns to IDLE.
REQ-026 Stall: m_stall=1 in WAIT and DONE; this gives one accepted instruction every LATENCY+2 cycles for memory ops and every 2 cycles otherwise.
REQ-027 Idle cycles: any cycle not loading the W_* registers drives W_valid=0 and holds the other W_* values.
REQ-028 Write timing: a write commits on the same edge that enters DONE, so a read immediately following it returns the new data.
REQ-029 Halt: after a DONE with W_stat != AOK, halted=1 and no further input is accepted; memory contents are frozen.
REQ-030 Halt source: HLT icode with M_stat=AOK produces W_stat=HLT.
REQ-031 Pass-through: W_valE equals the accepted M_valE for all ops.

Reset
REQ-032 rst_n=0 asynchronously forces state IDLE, counter 0, halted=0, W_valid=0, W_stat=AOK and all other W_* outputs to 0.
REQ-033 Reset mid-WAIT abandons the access; a pending write is not committed.
REQ-034 Memory array contents are not reset.

Structure
REQ-035 Package y86_pkg: holds the icode constants HALT..POPQ (0..B), the stat codes AOK/HLT/ADR/INS, the FSM state enum, and RNONE=4'hF.
REQ-036 Sub-module y86_dmem: single-port synchronous RAM, DEPTH x DATA_W, with write-enable, word index and read data; no reset.

Verification
REQ-037 Store then load: LATENCY=2; RMMOVQ valA=0x123, valE=0x40, then MRMOVQ valE=0x40 -> W_valM=0x123, W_stat=AOK; each op gives m_stall=1 for 3 cycles.
REQ-038 LATENCY=0: OPQ valE=7 -> W_valid=1, W_valE=7 one cycle after acceptance, m_stall=1 for 1 cycle.
REQ-039 Misaligned address: MRMOVQ valE=0x41 -> W_stat=ADR, W_valM=0, halted=1; a following RMMOVQ is ignored and memory is unchanged.
REQ-040 Out-of-range write: PUSHQ valE=0x2000 (DEPTH=1024) -> W_stat=ADR, no write occurs.
REQ-041 Reset during WAIT: RMMOVQ valA=5, valE=0x80, pulse rst_n low during WAIT -> outputs at reset values; a later MRMOVQ at 0x80 returns the prior contents.
REQ-042 Halt: HALT icode with M_stat=AOK -> W_stat=HLT, halted=1, m_stall=0 with further M_valid ignored.
